// File: rtl/timer.sv
// Programmable down-counting timer with selectable prescaler, periodic reload
// and a registered one-cycle expiry interrupt.
module timer (
    input  logic       clk,
    input  logic [7:0] ctrl,
    input  logic [7:0] set,
    output logic [7:0] read,
    output logic       irq,
    input  logic       rst
);

    localparam int unsigned CNT_W = 8;
    localparam int unsigned PSC_W = 12;

    typedef struct packed {
        logic [2:0] rsvd;
        logic [1:0] psc_sel;
        logic       ie;
        logic       reload;
        logic       en;
    } ctrl_t;

    ctrl_t            ctrl_s;
    logic [CNT_W-1:0] count;
    logic [PSC_W-1:0] prescaler;
    logic             tick_c;
    logic             unused_ctrl;

    assign ctrl_s      = ctrl_t'(ctrl);
    assign unused_ctrl = ^ctrl_s.rsvd;
    assign read        = count;

    // Tick when the prescaler's selected low bits are all ones
    always_comb begin
        tick_c = 1'b0;
        if (ctrl_s.en) begin
            unique case (ctrl_s.psc_sel)
                2'b00:   tick_c = 1'b1;
                2'b01:   tick_c = &prescaler[3:0];
                2'b10:   tick_c = &prescaler[7:0];
                default: tick_c = &prescaler;
            endcase
        end
    end

    // Count/prescaler/irq state; disabled timer continuously preloads the period
    always_ff @(posedge clk) begin
        if (rst) begin
            count     <= CNT_W'(0);
            prescaler <= PSC_W'(0);
            irq       <= 1'b0;
        end else if (!ctrl_s.en) begin
            count     <= set;
            prescaler <= PSC_W'(0);
            irq       <= 1'b0;
        end else begin
            prescaler <= prescaler + PSC_W'(1);
            irq       <= 1'b0;
            if (tick_c) begin
                if (count > CNT_W'(1)) begin
                    count <= count - CNT_W'(1);
                end else if (count == CNT_W'(1)) begin
                    count <= ctrl_s.reload ? set : CNT_W'(0);
                    irq   <= ctrl_s.ie;
                end
            end
        end
    end

endmodule

// File: tb/tb_timer.sv
// Directed testbench for timer: inputs change and outputs are sampled on the
// falling edge, so each step spans exactly one rising edge.
module tb_timer;

    logic       clk;
    logic       rst;
    logic [7:0] ctrl;
    logic [7:0] set;
    logic [7:0] read;
    logic       irq;

    int vec_cnt = 0;
    int err_cnt = 0;

    timer dut (
        .clk  (clk),
        .ctrl (ctrl),
        .set  (set),
        .read (read),
        .irq  (irq),
        .rst  (rst)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic check_out(input string tag, input logic [7:0] exp_read, input logic exp_irq);
        check({tag, ".read"}, read, exp_read);
        check({tag, ".irq"}, {7'd0, irq}, {7'd0, exp_irq});
    endtask

    initial begin
        rst  = 1'b1;
        ctrl = 8'h07;
        set  = 8'd9;
        step();
        step();
        check_out("reset", 8'd0, 1'b0);

        // Periodic /1, set=5: read 4,3,2,1,5,... irq with each reload
        rst  = 1'b0;
        ctrl = 8'h00;
        set  = 8'd5;
        step();
        check_out("periodic_load", 8'd5, 1'b0);
        ctrl = 8'h07;
        for (int k = 1; k <= 12; k++) begin
            step();
            check_out($sformatf("periodic_k%0d", k),
                      (k % 5 == 0) ? 8'd5 : 8'(5 - (k % 5)), (k % 5) == 0);
        end

        // One-shot /1, set=3, then restart via EN toggle
        ctrl = 8'h00;
        set  = 8'd3;
        step();
        ctrl = 8'h05;
        for (int k = 1; k <= 8; k++) begin
            step();
            check_out($sformatf("oneshot_k%0d", k), (k < 3) ? 8'(3 - k) : 8'd0, k == 3);
        end
        ctrl = 8'h04;
        step();
        check_out("oneshot_off", 8'd3, 1'b0);
        ctrl = 8'h05;
        for (int k = 1; k <= 4; k++) begin
            step();
            check_out($sformatf("oneshot_re_k%0d", k), (k < 3) ? 8'(3 - k) : 8'd0, k == 3);
        end

        // Periodic /16, set=2: ticks at edges 16 and 32
        ctrl = 8'h00;
        set  = 8'd2;
        step();
        ctrl = 8'h0F;
        for (int k = 1; k <= 33; k++) begin
            step();
            check_out($sformatf("div16_k%0d", k),
                      (k >= 16 && k < 32) ? 8'd1 : 8'd2, k == 32);
        end

        // Periodic with IE=0, set=4: reloads but never interrupts
        ctrl = 8'h00;
        set  = 8'd4;
        step();
        ctrl = 8'h03;
        for (int k = 1; k <= 8; k++) begin
            step();
            check_out($sformatf("noie_k%0d", k),
                      (k % 4 == 0) ? 8'd4 : 8'(4 - (k % 4)), 1'b0);
        end

        // set changes mid-count: current period finishes at 10, then period 2
        ctrl = 8'h00;
        set  = 8'd10;
        step();
        ctrl = 8'h07;
        for (int k = 1; k <= 15; k++) begin
            if (k == 4) set = 8'd2;
            step();
            if (k < 10)
                check_out($sformatf("setchg_k%0d", k), 8'(10 - k), 1'b0);
            else
                check_out($sformatf("setchg_k%0d", k), (k % 2 == 0) ? 8'd2 : 8'd1, (k % 2) == 0);
        end

        // EN falls in the expiry cycle: reload from set, no irq
        ctrl = 8'h00;
        set  = 8'd2;
        step();
        ctrl = 8'h07;
        step();
        check_out("enfall_pre", 8'd1, 1'b0);
        ctrl = 8'h06;
        set  = 8'd7;
        step();
        check_out("enfall", 8'd7, 1'b0);

        // PSC change without prescaler clear: /1 for 15 edges, then /16 ticks at once
        ctrl = 8'h00;
        set  = 8'd200;
        step();
        ctrl = 8'h05;
        for (int k = 1; k <= 15; k++) step();
        check_out("psc_pre", 8'd185, 1'b0);
        ctrl = 8'h0D;
        step();
        check_out("psc_switch", 8'd184, 1'b0);
        step();
        check_out("psc_hold", 8'd184, 1'b0);

        // Reset mid-count discards pending expiry; idle until EN toggles
        ctrl = 8'h00;
        set  = 8'd5;
        step();
        ctrl = 8'h07;
        step();
        step();
        check_out("rstmid_pre", 8'd3, 1'b0);
        rst = 1'b1;
        step();
        check_out("rstmid", 8'd0, 1'b0);
        rst = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            step();
            check_out($sformatf("rstidle_k%0d", k), 8'd0, 1'b0);
        end
        ctrl = 8'h00;
        step();
        check_out("rst_reen_off", 8'd5, 1'b0);
        ctrl = 8'h07;
        step();
        check_out("rst_reen_on", 8'd4, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule

// File: doc/timer.md
TIMER -- requirements
Module: timer

Interface
REQ-001 SHALL have no parameters; the prescaler divisors and field widths below are fixed.
REQ-002 SHALL have port `clk`, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port `rst`, input, 1 bit: reset, synchronous and active-high.
REQ-004 SHALL have port `ctrl`, input, 8 bits: control level.
- [0] EN: enable.
- [1] RELOAD: periodic mode.
- [2] IE: interrupt enable.
- [4:3] PSC: prescaler select.
- [7:5] reserved, ignored.
REQ-005 SHALL have port `set`, input, 8 bits: period/reload value, in prescaled ticks.
REQ-006 SHALL have port `read`, output, 8 bits: current count, driven directly from the count register.
REQ-007 SHALL have port `irq`, output, 1 bit: registered expiry pulse.
REQ-008 SHALL keep port order clk, ctrl, set, read, irq, rst, so that positional instantiation of the first five ports is preserved.

Function
REQ-009 SHALL contain an 8-bit count register, a 12-bit prescaler counter, and a 1-bit irq register.
REQ-010 While EN=0, each cycle SHALL set:
- count <= set
- prescaler <= 0
- irq <= 0
REQ-011 While EN=1, the prescaler SHALL increment each cycle and wrap modulo 4096.
REQ-012 A tick SHALL occur in a cycle where EN=1 and the prescaler's low bits selected by PSC are all ones:
- PSC=00: every cycle (/1)
- PSC=01: low 4 bits (/16)
- PSC=10: low 8 bits (/256)
- PSC=11: all 12 bits (/4096)
REQ-013 On a tick with count>1, count SHALL decrement by 1.
REQ-014 On a tick with count==1 (expiry):
- count SHALL become `set` sampled that cycle if RELOAD=1, else 0.
- irq SHALL be 1 for the next cycle only, and only if IE=1.
REQ-015 With count==0 and EN=1, count SHALL hold 0, with no further expiry and no irq; this covers one-shot done and set==0 (timer idle).
REQ-016 A one-shot timer SHALL restart only by clearing EN for at least one cycle and then setting it again.
REQ-017 irq SHALL be 0 in every cycle not immediately following an expiry with IE=1; it is never asserted for two consecutive cycles.
REQ-018 A change of `set` while EN=1 SHALL take effect only at the next reload; the current count is unaffected.
REQ-019 A change of PSC while EN=1 SHALL take effect immediately; the prescaler is not cleared.
REQ-020 Clearing IE while EN=1 SHALL suppress irq but SHALL NOT alter counting or reload.
REQ-021 If EN falls in the same cycle as an expiry, EN=0 SHALL take priority: count <= set, no irq.
REQ-022 Interval between consecutive irq pulses in periodic mode SHALL be set × divisor cycles.
REQ-023 First irq after an EN rising edge SHALL arrive set × divisor cycles after EN rises, ± one prescaler phase; with PSC=00 it is exactly set cycles.

Reset
REQ-024 When rst=1 at a clock edge:
- count <= 0
- prescaler <= 0
- irq <= 0
REQ-025 rst SHALL take priority over EN and ticks.
REQ-026 After rst deasserts with EN=1 and count 0, the timer SHALL stay idle until EN is cleared and set again.
REQ-027 Reset mid-count SHALL discard any pending expiry.

Verification
REQ-028 ctrl=0x07 (EN, RELOAD, IE, /1), set=5 after EN low → irq one-cycle pulses every 5 cycles; read sequence 5,4,3,2,1,5,…
REQ-029 ctrl=0x05 (one-shot, /1), set=3 → exactly one irq; then read holds 0 with no further irq; clear EN one cycle, re-enable → another irq after 3 cycles.
REQ-030 ctrl=0x0F (/16), set=2 → irq period 32 cycles; read changes only every 16 cycles.
REQ-031 ctrl=0x03 (IE=0), set=4 → read reloads 4 every 4 cycles; irq stays 0.
REQ-032 Running with set=10, change set to 2 mid-count → current period completes at 10; subsequent periods are 2.
REQ-033 Assert rst mid-count with count=3 → next cycle read=0, irq=0; EN held → no irq thereafter until EN toggles.
